seq1101_tx: RTL and testbench

Serial bit-stream generator: the transmit end of the 1101 detector's single-bit `in` interface.
- Loads a parallel word of programmable length and shifts it out MSB-first, one bit per clock.
- Can repeat the frame with a programmable idle gap between copies.
- Drives detector stimulus in system test and acts as the pattern source on the board.
- Has a start/busy/done handshake with the controlling logic.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq1101_tx.sv | 142 ++++++++++++++
 tb/tb_seq1101_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and pattern constants for the 1101 transmitter/detector pair
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] PAT_1101 = 4'b1101;
   localparam int         PAT_LEN  = 4;

endpackage

// File: rtl/seq1101_tx.sv
// rtl/seq1101_tx.sv - MSB-first serial frame generator with repeat count and idle gap
module seq1101_tx
   import seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4,
   parameter int GAP   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WIDTH-1:0]           data,
   input  logic [$clog2(WIDTH):0]     nbits,
   input  logic [CNT_W-1:0]           rep,
   output logic                       out,
   output logic                       valid,
   output logic                       busy,
   output logic                       done
);

   localparam int NB_W  = $clog2(WIDTH) + 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   frame_q, frame_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [NB_W-1:0]    nbits_q, nbits_d;
   logic [NB_W-1:0]    bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;
   logic               out_q, out_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // frame_q holds the active field left-aligned so the next bit is always bit WIDTH-1;
   // bitcnt_q counts bits still to follow the one currently on out.
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      shreg_d  = shreg_q;
      nbits_d  = nbits_q;
      bitcnt_d = bitcnt_q;
      rep_d    = rep_q;
      gapcnt_d = gapcnt_q;
      out_d    = out_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && (nbits != '0) && (nbits <= NB_W'(WIDTH))) begin
               frame_d  = data << (NB_W'(WIDTH) - nbits);
               nbits_d  = nbits;
               rep_d    = rep;
               out_d    = frame_d[WIDTH-1];
               shreg_d  = frame_d << 1;
               bitcnt_d = nbits - 1'b1;
               valid_d  = 1'b1;
               busy_d   = 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bitcnt_q != '0) begin
               out_d    = shreg_q[WIDTH-1];
               shreg_d  = shreg_q << 1;
               bitcnt_d = bitcnt_q - 1'b1;
            end else if (rep_q != '0) begin
               rep_d = rep_q - 1'b1;
               if (GAP > 0) begin
                  state_d  = ST_GAP;
                  gapcnt_d = GAP_W'(GAP - 1);
                  out_d    = 1'b0;
                  valid_d  = 1'b0;
               end else begin
                  out_d    = frame_q[WIDTH-1];
                  shreg_d  = frame_q << 1;
                  bitcnt_d = nbits_q - 1'b1;
               end
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               out_d   = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         ST_GAP: begin
            if (gapcnt_q != '0) begin
               gapcnt_d = gapcnt_q - 1'b1;
            end else begin
               state_d  = ST_SHIFT;
               out_d    = frame_q[WIDTH-1];
               shreg_d  = frame_q << 1;
               bitcnt_d = nbits_q - 1'b1;
               valid_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         frame_q  <= '0;
         shreg_q  <= '0;
         nbits_q  <= '0;
         bitcnt_q <= '0;
         rep_q    <= '0;
         gapcnt_q <= '0;
         out_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         shreg_q  <= shreg_d;
         nbits_q  <= nbits_d;
         bitcnt_q <= bitcnt_d;
         rep_q    <= rep_d;
         gapcnt_q <= gapcnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq1101_tx.sv
// tb/tb_seq1101_tx.sv - directed self-checking bench for seq1101_tx
module tb_seq1101_tx;
   import seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] data;
   logic [4:0]  nbits;
   logic [3:0]  rep;
   logic        out, valid, busy, done;

   int checks   = 0;
   int failures = 0;

   logic [63:0] outs, vals;
   int          dcyc;
   int          hits;
   logic [7:0]  hitmask;
   logic [3:0]  win;

   seq1101_tx #(.WIDTH(16), .CNT_W(4), .GAP(2)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .data  (data),
      .nbits (nbits),
      .rep   (rep),
      .out   (out),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accepts a frame, then records out/valid each cycle until done (bounded).
   task automatic send(input logic [15:0] d, input logic [4:0] n, input logic [3:0] r,
                       input bit inject, output logic [63:0] o, output logic [63:0] v,
                       output int dc);
      data  = d;
      nbits = n;
      rep   = r;
      start = 1'b1;
      tick();
      start = 1'b0;
      o  = '0;
      v  = '0;
      dc = 0;
      for (int c = 1; c <= 100; c++) begin
         if (inject && c == 2) begin
            start = 1'b1;
            data  = 16'hFFFF;
            nbits = 5'd16;
            rep   = 4'd3;
         end else if (inject && c == 3) begin
            start = 1'b0;
         end
         if (done) begin
            dc = c;
            break;
         end
         chk("busy_during_frame", 64'(busy), 64'd1);
         chk("out_zero_when_invalid", 64'(out & ~valid), 64'd0);
         o = {o[62:0], out};
         v = {v[62:0], valid};
         tick();
      end
      chk("done_cycle_idle_outputs", {61'd0, out, valid, busy}, 64'd0);
      tick();
      chk("done_single_pulse", 64'(done), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      data  = '0;
      nbits = '0;
      rep   = '0;
      tick();
      tick();
      chk("reset_outputs", {60'd0, out, valid, busy, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("idle_after_reset", {60'd0, out, valid, busy, done}, 64'd0);

      // single 4-bit frame
      send(16'h000D, 5'd4, 4'd0, 1'b0, outs, vals, dcyc);
      chk("a_bits", outs, 64'hD);
      chk("a_valid", vals, 64'hF);
      chk("a_done_cycle", 64'(dcyc), 64'd5);

      // 7-bit frame with overlapping 1101 occurrences
      send(16'h006D, 5'd7, 4'd0, 1'b0, outs, vals, dcyc);
      chk("b_bits", outs, 64'h6D);
      chk("b_valid", vals, 64'h7F);
      chk("b_done_cycle", 64'(dcyc), 64'd8);
      hits    = 0;
      hitmask = '0;
      win     = '0;
      for (int i = 6; i >= 0; i--) begin
         win = {win[2:0], outs[i]};
         if (win == PAT_1101) begin
            hits++;
            hitmask[7 - i] = 1'b1;
         end
      end
      chk("b_detect_count", 64'(hits), 64'd2);
      chk("b_detect_cycles", 64'(hitmask), 64'h90);
      chk("b_pat_len", 64'(PAT_LEN), 64'(dcyc - 4));

      // repeated frame with 2-cycle gaps
      send(16'h000D, 5'd4, 4'd2, 1'b0, outs, vals, dcyc);
      chk("c_bits", outs, 64'hD34D);
      chk("c_valid", vals, 64'hF3CF);
      chk("c_done_cycle", 64'(dcyc), 64'd17);

      // start during SHIFT must not disturb the frame in flight
      send(16'h000D, 5'd4, 4'd0, 1'b1, outs, vals, dcyc);
      chk("d_bits", outs, 64'hD);
      chk("d_valid", vals, 64'hF);
      chk("d_done_cycle", 64'(dcyc), 64'd5);

      // illegal lengths are ignored while idle
      data  = 16'hFFFF;
      nbits = 5'd0;
      start = 1'b1;
      tick();
      chk("nbits0_ignored", {62'd0, busy, valid}, 64'd0);
      nbits = 5'd17;
      tick();
      chk("nbits17_ignored", {62'd0, busy, valid}, 64'd0);
      tick();
      chk("nbits17_still_idle", {62'd0, busy, valid}, 64'd0);
      start = 1'b0;

      // asynchronous reset during bit 2
      data  = 16'h000D;
      nbits = 5'd4;
      rep   = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("e_bit2_live", {61'd0, out, valid, busy}, 64'h7);
      #2;
      reset = 1'b1;
      #1;
      chk("e_async_reset", {60'd0, out, valid, busy, done}, 64'd0);
      tick();
      chk("e_no_done", {60'd0, out, valid, busy, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      send(16'h000D, 5'd4, 4'd0, 1'b0, outs, vals, dcyc);
      chk("e_bits_after", outs, 64'hD);
      chk("e_done_after", 64'(dcyc), 64'd5);

      // full-width frame
      send(16'hA5C3, 5'd16, 4'd0, 1'b0, outs, vals, dcyc);
      chk("f_bits", outs, 64'hA5C3);
      chk("f_valid", vals, 64'hFFFF);
      chk("f_done_cycle", 64'(dcyc), 64'd17);

      // start held through DONE is only accepted in the following IDLE cycle
      data  = 16'h000D;
      nbits = 5'd4;
      rep   = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("g_done_pulse", 64'(done), 64'd1);
      start = 1'b1;
      tick();
      chk("g_start_in_done_ignored", {62'd0, busy, valid}, 64'd0);
      tick();
      chk("g_accept_from_idle", {61'd0, out, valid, busy}, 64'h7);
      start = 1'b0;
      repeat (4) tick();
      chk("g_done_again", 64'(done), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
